stream_protocol_monitor: RTL and testbench
==========================================

# stream_protocol_monitor

Synthesizable, parametrised AXI4-Stream video protocol monitor. It passively taps the pixel generator's output stream and checks the framing: SOF on `tuser`, EOL on `tlast`, line length, lines per frame and stalls on `tvalid`. Results go to saturating error counters, a frame counter and position/status outputs, so framing faults are visible in hardware (ILA or AXI-Lite status registers) and not only in simulation. It never drives the stream.

## Interface
- `X_SIZE`, 1440: words per line.
- `Y_SIZE`, 1080: lines per frame.
- `TIMEOUT`, 1000: consecutive cycles with `tvalid` low, while synced, that count as a stall.
- `CNT_W`, 16: width of the frame counter and of every error counter.
- `out_stream_aclk` in 1: the single clock.
- `axi_resetn` in 1: reset, asynchronous and active-low.
- `out_stream_tvalid` in 1: tapped stream valid.
- `out_stream_tready` in 1: tapped stream ready.
- `out_stream_tuser` in 1: SOF, tapped.
- `out_stream_tlast` in 1: EOL, tapped.
- `clear` in 1: synchronous clear of the counters and the sticky flag.
- `synced` out 1: an SOF has been seen since reset.
- `x_pos` out XW: next expected word index, where XW = $clog2(X_SIZE)+1.
- `y_pos` out YW: current line, where YW = $clog2(Y_SIZE).
- `frame_count` out CNT_W: SOF-started frames.
- `err_missing_sof`, `err_unexp_sof`, `err_missing_eol`, `err_early_eol`, `err_timeout` out CNT_W each: error counters.
- `frame_done` out 1: one-cycle pulse after a correctly terminated frame.
- `error` out 1: sticky OR of all error events.

## Operation
- Beat = `tvalid && tready` on a rising edge. Only beats update the position state.
- States:
  - WAIT_SOF, the reset state. Non-SOF beats are discarded: no position change, no errors. An SOF beat goes to IN_FRAME and is processed as word 0 of line 0.
  - IN_FRAME: stays there until reset.
- Per beat in IN_FRAME, the SOF check happens first:
  - Expected SOF is x=0 and y=0.
  - SOF when expected: `frame_count`+1.
  - SOF when not expected: `err_unexp_sof`+1, `frame_count`+1, then x and y are forced to 0 (resync).
  - Expected but no SOF: `err_missing_sof`+1; the beat still counts as word 0.
- EOL check uses x after the SOF step:
  - x = X_SIZE-1 with EOL: x goes to 0 and y increments.
  - x = X_SIZE-1 without EOL: `err_missing_eol`+1, x increments.
  - x > X_SIZE-1 (overlong line): no further errors. x saturates at 2^XW-1. The next EOL sets x to 0 and increments y.
  - EOL with x < X_SIZE-1: `err_early_eol`+1, x goes to 0 and y increments.
  - No EOL and x < X_SIZE-1: x increments.
- y wraps to 0 when it would reach Y_SIZE.
- `frame_done` pulses when an EOL beat at x=X_SIZE-1, y=Y_SIZE-1 had no error on that beat.
- Timeout:
  - The counter clears on `tvalid` high and increments otherwise, only while `synced`.
  - On reaching TIMEOUT it clears itself and `err_timeout`+1, so a continuous stall counts once per TIMEOUT cycles.
- Counters saturate at 2^CNT_W-1. Any error event sets `error`.
- `clear`:
  - Zeroes all counters, `error` and the timeout counter.
  - Leaves state, x and y untouched.
  - If `clear` and an event occur in the same cycle, `clear` wins.

## Timing
- All outputs are registered. A beat at edge N is reflected in the outputs after edge N.
- `frame_done` is high for exactly the cycle after that edge.
- Reset values: state WAIT_SOF, `synced`=0, `x_pos`=0, `y_pos`=0, all counters 0, `frame_done`=0, `error`=0.
- Reset asserted mid-frame returns everything to the reset values immediately, without waiting for a clock edge. After release, the monitor waits for the next SOF.
- No combinational input-to-output paths.
- Stall cycles (`tvalid` high, `tready` low) do not advance position and do not count toward timeout.

## Test plan
All scenarios use X_SIZE=8, Y_SIZE=4, TIMEOUT=20, CNT_W=4.
- Two clean frames, always-ready: `frame_count`=2, `frame_done` pulsed twice, all error counters 0, `error`=0, final x=0, y=0.
- 50% pseudo-random `tready` over three clean frames: identical counts to the always-ready case, and `x_pos` stays stable during stalls.
- EOL dropped on line 1 and sent on word 9: `err_missing_eol`=1, no early-EOL error, next line starts at x=0, y=2, no `frame_done` for that frame.
- EOL on word 5 of line 2: `err_early_eol`=1, x=0, y=3.
- SOF injected at word 3 of line 2: `err_unexp_sof`=1, `frame_count` increments, x=1, y=0 after the beat. A frame starting without SOF gives `err_missing_sof`=1.
- Saturation, clear, stall and reset:
  - 25 cycles of `tvalid` low after sync: `err_timeout`=1.
  - Force 20 early EOLs: `err_early_eol` saturates at 15.
  - Pulse `clear`: all counters 0, `error`=0.
  - Assert reset mid-line: `synced`=0, and pre-SOF beats after release are ignored.

Source files
------------

// File: rtl/stream_protocol_monitor.sv
`default_nettype none
// ============================================================================
// Module      : stream_protocol_monitor
// Description : Passive AXI4-Stream video framing monitor. Taps the stream
//               (tvalid/tready/tuser/tlast) and checks SOF placement, EOL
//               placement, line length, lines per frame and tvalid stalls.
//               Outcomes go to saturating error counters, a frame counter, a
//               one-cycle frame_done pulse and a sticky error flag.
// Ports       : out_stream_aclk/axi_resetn - clock, async active-low reset
//               out_stream_t*              - tapped stream (inputs only)
//               clear                      - sync clear of counters/flag
//               synced, x_pos, y_pos       - sync status and position
//               frame_count, err_*         - saturating counters
//               frame_done, error          - frame pulse, sticky error
// Revision    : 1.0 - initial release
// ============================================================================
module stream_protocol_monitor #(
   parameter int X_SIZE  = 1440,
   parameter int Y_SIZE  = 1080,
   parameter int TIMEOUT = 1000,
   parameter int CNT_W   = 16,
   localparam int XW     = $clog2(X_SIZE) + 1,
   localparam int YW     = $clog2(Y_SIZE)
) (
   input  logic             out_stream_aclk,
   input  logic             axi_resetn,
   input  logic             out_stream_tvalid,
   input  logic             out_stream_tready,
   input  logic             out_stream_tuser,
   input  logic             out_stream_tlast,
   input  logic             clear,
   output logic             synced,
   output logic [XW-1:0]    x_pos,
   output logic [YW-1:0]    y_pos,
   output logic [CNT_W-1:0] frame_count,
   output logic [CNT_W-1:0] err_missing_sof,
   output logic [CNT_W-1:0] err_unexp_sof,
   output logic [CNT_W-1:0] err_missing_eol,
   output logic [CNT_W-1:0] err_early_eol,
   output logic [CNT_W-1:0] err_timeout,
   output logic             frame_done,
   output logic             error
);

   localparam int            TW        = $clog2(TIMEOUT + 1);
   localparam logic [XW-1:0] c_X_LAST  = XW'(X_SIZE - 1);
   localparam logic [YW-1:0] c_Y_LAST  = YW'(Y_SIZE - 1);
   localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      S_WAIT_SOF = 1'b0,
      S_IN_FRAME = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [XW-1:0]    x_q, x_d, w_x_base;
   logic [YW-1:0]    y_q, y_d, w_y_base;
   logic [TW-1:0]    to_q, to_d;
   logic [CNT_W-1:0] fc_q, ms_q, us_q, me_q, ee_q, tmo_q;
   logic             frame_done_q, error_q;

   logic w_in_frame, w_accept, w_sof_exp;
   logic w_ev_frame, w_ev_unexp, w_ev_miss_sof, w_ev_miss_eol, w_ev_early;
   logic w_ev_to, w_ev_done, w_ev_any;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      w_in_frame = (state_q == S_IN_FRAME);
      // Before sync only SOF beats are processed; everything else is discarded.
      w_accept   = out_stream_tvalid && out_stream_tready &&
                   (w_in_frame || out_stream_tuser);
      w_sof_exp  = (x_q == '0) && (y_q == '0);

      w_ev_frame    = w_accept && out_stream_tuser;
      w_ev_unexp    = w_ev_frame && w_in_frame && !w_sof_exp;
      w_ev_miss_sof = w_accept && !out_stream_tuser && w_sof_exp;

      // An unexpected SOF resynchronises the position before the EOL check.
      w_x_base = w_ev_unexp ? '0 : x_q;
      w_y_base = w_ev_unexp ? '0 : y_q;

      w_ev_miss_eol = w_accept && !out_stream_tlast && (w_x_base == c_X_LAST);
      w_ev_early    = w_accept &&  out_stream_tlast && (w_x_base <  c_X_LAST);
      w_ev_done     = w_accept && out_stream_tlast &&
                      (w_x_base == c_X_LAST) && (w_y_base == c_Y_LAST) &&
                      !w_ev_unexp && !w_ev_miss_sof;

      state_d = state_q;
      if (w_ev_frame) begin
         state_d = S_IN_FRAME;
      end

      x_d = x_q;
      y_d = y_q;
      if (w_accept) begin
         if (out_stream_tlast) begin
            x_d = '0;
            y_d = (w_y_base == c_Y_LAST) ? '0 : w_y_base + YW'(1);
         end else begin
            // Overlong lines hold x at its maximum until the next EOL.
            x_d = (&w_x_base) ? w_x_base : w_x_base + XW'(1);
            y_d = w_y_base;
         end
      end

      to_d    = to_q;
      w_ev_to = 1'b0;
      if (w_in_frame) begin
         if (out_stream_tvalid) begin
            to_d = '0;
         end else if (to_q == c_TO_LAST) begin
            to_d    = '0;
            w_ev_to = 1'b1;
         end else begin
            to_d = to_q + TW'(1);
         end
      end
      if (clear) begin
         to_d = '0;
      end

      w_ev_any = w_ev_unexp | w_ev_miss_sof | w_ev_miss_eol | w_ev_early | w_ev_to;
   end

   always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q      <= S_WAIT_SOF;
         x_q          <= '0;
         y_q          <= '0;
         to_q         <= '0;
         fc_q         <= '0;
         ms_q         <= '0;
         us_q         <= '0;
         me_q         <= '0;
         ee_q         <= '0;
         tmo_q        <= '0;
         frame_done_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         to_q         <= to_d;
         frame_done_q <= w_ev_done;
         if (clear) begin
            fc_q    <= '0;
            ms_q    <= '0;
            us_q    <= '0;
            me_q    <= '0;
            ee_q    <= '0;
            tmo_q   <= '0;
            error_q <= 1'b0;
         end else begin
            if (w_ev_frame)    fc_q  <= sat_inc(fc_q);
            if (w_ev_miss_sof) ms_q  <= sat_inc(ms_q);
            if (w_ev_unexp)    us_q  <= sat_inc(us_q);
            if (w_ev_miss_eol) me_q  <= sat_inc(me_q);
            if (w_ev_early)    ee_q  <= sat_inc(ee_q);
            if (w_ev_to)       tmo_q <= sat_inc(tmo_q);
            if (w_ev_any)      error_q <= 1'b1;
         end
      end
   end

   assign synced          = (state_q == S_IN_FRAME);
   assign x_pos           = x_q;
   assign y_pos           = y_q;
   assign frame_count     = fc_q;
   assign err_missing_sof = ms_q;
   assign err_unexp_sof   = us_q;
   assign err_missing_eol = me_q;
   assign err_early_eol   = ee_q;
   assign err_timeout     = tmo_q;
   assign frame_done      = frame_done_q;
   assign error           = error_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_protocol_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_protocol_monitor
// Description : Self-checking bench for stream_protocol_monitor with
//               X_SIZE=8, Y_SIZE=4, TIMEOUT=20, CNT_W=4. A behavioural model
//               of the framing rules predicts every output each cycle;
//               directed scenario checks add fixed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_protocol_monitor;

   localparam int X    = 8;
   localparam int Y    = 4;
   localparam int T    = 20;
   localparam int C    = 4;
   localparam int XW   = $clog2(X) + 1;
   localparam int YW   = $clog2(Y);
   localparam int XSAT = (1 << XW) - 1;
   localparam int CMAX = (1 << C) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          tv, tr, tu, tl, clr;
   logic          synced, frame_done, error;
   logic [XW-1:0] x_pos;
   logic [YW-1:0] y_pos;
   logic [C-1:0]  frame_count, e_ms, e_us, e_me, e_ee, e_to;

   int n_cmp = 0;
   int n_mis = 0;
   int n_done_seen = 0;

   // reference model state
   bit m_sync, m_err, m_done;
   int m_x, m_y, m_fc, m_ms, m_us, m_me, m_ee, m_to, m_idle;

   stream_protocol_monitor #(.X_SIZE(X), .Y_SIZE(Y), .TIMEOUT(T), .CNT_W(C)) dut (
      .out_stream_aclk   (clk),
      .axi_resetn        (rst_n),
      .out_stream_tvalid (tv),
      .out_stream_tready (tr),
      .out_stream_tuser  (tu),
      .out_stream_tlast  (tl),
      .clear             (clr),
      .synced            (synced),
      .x_pos             (x_pos),
      .y_pos             (y_pos),
      .frame_count       (frame_count),
      .err_missing_sof   (e_ms),
      .err_unexp_sof     (e_us),
      .err_missing_eol   (e_me),
      .err_early_eol     (e_ee),
      .err_timeout       (e_to),
      .frame_done        (frame_done),
      .error             (error)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int c);
      return (c < CMAX) ? c + 1 : CMAX;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sync = 0; m_err = 0; m_done = 0;
      m_x = 0; m_y = 0; m_fc = 0; m_ms = 0; m_us = 0;
      m_me = 0; m_ee = 0; m_to = 0; m_idle = 0;
   endtask

   // Applies the framing rules for one rising edge with the given inputs.
   task automatic model_edge(input bit v, input bit r, input bit u, input bit l, input bit c);
      bit was_sync;
      bit err;
      bit done;
      bit at_origin;
      was_sync = m_sync;
      err  = 0;
      done = 0;
      if (v && r && (m_sync || u)) begin
         at_origin = (m_x == 0) && (m_y == 0);
         m_sync = 1;
         if (u) begin
            m_fc = sat(m_fc);
            if (!at_origin) begin
               m_us = sat(m_us); err = 1; m_x = 0; m_y = 0;
            end
         end else if (at_origin) begin
            m_ms = sat(m_ms); err = 1;
         end
         if (l) begin
            if (m_x < X - 1) begin
               m_ee = sat(m_ee); err = 1;
            end else if (m_x == X - 1 && m_y == Y - 1 && !err) begin
               done = 1;
            end
            m_x = 0;
            m_y = (m_y + 1) % Y;
         end else begin
            if (m_x == X - 1) begin
               m_me = sat(m_me); err = 1;
            end
            if (m_x < XSAT) m_x = m_x + 1;
         end
      end
      if (was_sync) begin
         if (v) m_idle = 0;
         else begin
            m_idle = m_idle + 1;
            if (m_idle == T) begin
               m_idle = 0; m_to = sat(m_to); err = 1;
            end
         end
      end
      if (c) begin
         m_fc = 0; m_ms = 0; m_us = 0; m_me = 0; m_ee = 0; m_to = 0;
         m_idle = 0; m_err = 0;
      end else if (err) begin
         m_err = 1;
      end
      m_done = done;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".synced"},      32'(synced),      32'(m_sync));
      chk({tag, ".x_pos"},       32'(x_pos),       32'(m_x));
      chk({tag, ".y_pos"},       32'(y_pos),       32'(m_y));
      chk({tag, ".frame_count"}, 32'(frame_count), 32'(m_fc));
      chk({tag, ".missing_sof"}, 32'(e_ms),        32'(m_ms));
      chk({tag, ".unexp_sof"},   32'(e_us),        32'(m_us));
      chk({tag, ".missing_eol"}, 32'(e_me),        32'(m_me));
      chk({tag, ".early_eol"},   32'(e_ee),        32'(m_ee));
      chk({tag, ".timeout"},     32'(e_to),        32'(m_to));
      chk({tag, ".frame_done"},  32'(frame_done),  32'(m_done));
      chk({tag, ".error"},       32'(error),       32'(m_err));
   endtask

   task automatic step(input bit v, input bit r, input bit u, input bit l, input bit c);
      tv = v; tr = r; tu = u; tl = l; clr = c;
      @(posedge clk);
      model_edge(v, r, u, l, c);
      #1;
      check_all("cyc");
      if (frame_done === 1'b1) n_done_seen++;
   endtask

   // One word; in random mode adds short tvalid gaps and tready stalls.
   task automatic send_word(input bit u, input bit l, input bit rnd);
      int gap;
      int tries;
      if (rnd) begin
         gap = $urandom_range(0, 2);
         for (int i = 0; i < gap; i++) step(0, $urandom_range(0, 1), 0, 0, 0);
         tries = 0;
         while (tries < 6 && $urandom_range(0, 1) == 0) begin
            step(1, 0, u, l, 0);
            tries++;
         end
      end
      step(1, 1, u, l, 0);
   endtask

   task automatic send_line(input int len, input int sof_at, input bit eol, input bit rnd);
      for (int i = 0; i < len; i++) send_word(i == sof_at, eol && (i == len - 1), rnd);
   endtask

   task automatic send_frame(input bit rnd);
      for (int y = 0; y < Y; y++) send_line(X, (y == 0) ? 0 : -1, 1, rnd);
   endtask

   initial begin
      int fc_before;
      rst_n = 1'b0; tv = 0; tr = 0; tu = 0; tl = 0; clr = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Two clean frames, always ready
      n_done_seen = 0;
      send_frame(0);
      send_frame(0);
      chk("clean.frame_count", 32'(frame_count), 2);
      chk("clean.done_pulses", 32'(n_done_seen), 2);
      chk("clean.error",       32'(error),       0);
      chk("clean.x",           32'(x_pos),       0);
      chk("clean.y",           32'(y_pos),       0);

      // Three clean frames with random tready and tvalid gaps
      step(0, 0, 0, 0, 1);
      n_done_seen = 0;
      repeat (3) send_frame(1);
      chk("rnd.frame_count", 32'(frame_count), 3);
      chk("rnd.done_pulses", 32'(n_done_seen), 3);
      chk("rnd.error",       32'(error),       0);
      chk("rnd.errsum",      32'(e_ms) + 32'(e_us) + 32'(e_me) + 32'(e_ee) + 32'(e_to), 0);

      // Line 1 drops EOL at word 7, EOL arrives on word 9
      step(0, 0, 0, 0, 1);
      send_line(X, 0, 1, 0);
      send_line(10, -1, 1, 0);
      chk("longline.missing_eol", 32'(e_me),  1);
      chk("longline.early_eol",   32'(e_ee),  0);
      chk("longline.x",           32'(x_pos), 0);
      chk("longline.y",           32'(y_pos), 2);

      // Line 2 ends early on word 5
      send_line(6, -1, 1, 0);
      chk("early.early_eol", 32'(e_ee),  1);
      chk("early.x",         32'(x_pos), 0);
      chk("early.y",         32'(y_pos), 3);
      send_line(X, -1, 1, 0);

      // SOF injected at word 3 of line 2
      send_line(X, 0, 1, 0);
      send_line(X, -1, 1, 0);
      send_line(3, -1, 0, 0);
      fc_before = m_fc;
      send_word(1, 0, 0);
      chk("unexp.unexp_sof",   32'(e_us),        1);
      chk("unexp.frame_count", 32'(frame_count), 32'(fc_before + 1));
      chk("unexp.x",           32'(x_pos),       1);
      chk("unexp.y",           32'(y_pos),       0);
      send_line(X - 1, -1, 1, 0);
      for (int y = 1; y < Y; y++) send_line(X, -1, 1, 0);
      // Frame that starts without SOF
      send_line(X, -1, 1, 0);
      chk("nosof.missing_sof", 32'(e_ms), 1);

      // Stall: 25 cycles of tvalid low while synced
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 25; i++) step(0, $urandom_range(0, 1), 0, 0, 0);
      chk("stall.timeout", 32'(e_to),  1);
      chk("stall.error",   32'(error), 1);

      // Early-EOL saturation
      for (int i = 0; i < 20; i++) send_word(0, 1, 0);
      chk("sat.early_eol", 32'(e_ee), CMAX);

      // Clear
      step(0, 0, 0, 0, 1);
      chk("clear.counts", 32'(frame_count) + 32'(e_ms) + 32'(e_us) + 32'(e_me) + 32'(e_ee) + 32'(e_to), 0);
      chk("clear.error",  32'(error), 0);
      chk("clear.synced", 32'(synced), 1);

      // Asynchronous reset mid-line
      send_line(X, 0, 1, 0);
      send_line(3, -1, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("asyncrst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) send_word(0, i == 4, $urandom_range(0, 1));
      chk("postrst.synced", 32'(synced),      0);
      chk("postrst.x",      32'(x_pos),       0);
      chk("postrst.fc",     32'(frame_count), 0);
      n_done_seen = 0;
      send_frame(1);
      chk("postrst.frame_count", 32'(frame_count), 1);
      chk("postrst.done_pulses", 32'(n_done_seen), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
